// File: rtl/fft_pkg.sv
// Shared definitions for the FFT frame controller: drain-FSM states and
// the width of the dropped-sample counter.
package fft_pkg;

  // Drain side walks a full bank through load, compute and release.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } drain_state_t;

  localparam int DROP_CNT_W = 16;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

endpackage

// File: rtl/pingpong_buffer.sv
// Two-bank sample store: one write port, one combinational read port and
// a full flag per bank. A release and a completing write may hit the same
// bank in one cycle; the release is applied first so the new fill wins.
module pingpong_buffer #(
  parameter int width = 16,
  parameter int N_2   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_wr_en,
  input  logic             i_wr_sel,
  input  logic [N_2-1:0]   i_wr_addr,
  input  logic [width-1:0] i_wr_data,
  input  logic             i_wr_last,
  input  logic             i_rel_en,
  input  logic             i_rel_sel,
  input  logic             i_rd_sel,
  input  logic [N_2-1:0]   i_rd_addr,
  output logic [width-1:0] o_rd_data,
  output logic [1:0]       o_full
);

  logic [width-1:0] r_mem [2**(N_2+1)];
  logic [1:0]       r_full;

  // Sample storage; bank select is the top address bit.
  // NOTE: the memory has no reset; the full flags alone say whether a bank holds valid data.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[{i_wr_sel, i_wr_addr}] <= i_wr_data;
    end
  end

  // Full flags: clear on release, then set on the last write of a bank.
  // NOTE: non-blocking updates let the later set override the earlier clear on the same bank.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_full <= '0;
    end else begin
      if (i_rel_en) begin
        r_full[i_rel_sel] <= 1'b0;
      end
      if (i_wr_en && i_wr_last) begin
        r_full[i_wr_sel] <= 1'b1;
      end
    end
  end

  assign o_rd_data = r_mem[{i_rd_sel, i_rd_addr}];
  assign o_full    = r_full;

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame controller between a sample stream and an FFT core. Incoming samples
// fill a ping-pong buffer; the drain FSM streams each full bank into the core,
// starts the transform and releases the bank when the core reports done.
// Optional: define FFT_DROP_COUNT_EN to enable the saturating drop counter.
module fft_frame_ctrl
  import fft_pkg::*;
#(
  parameter int width = 16,
  parameter int N_2   = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic signed [width-1:0] in_data,
  input  logic                    fft_done,
  output logic                    fft_load,
  output logic signed [width-1:0] fft_rd,
  output logic                    fft_start,
  output logic                    frame_done,
  output logic                    overflow,
  output logic [DROP_CNT_W-1:0]   drop_count
);

  drain_state_t     r_state;
  drain_state_t     w_next_state;
  logic             r_wsel;
  logic             r_rsel;
  logic [N_2-1:0]   r_widx;
  logic [N_2-1:0]   r_ridx;
  logic             r_overflow;
  logic [1:0]       w_full;
  logic [width-1:0] w_rd_data;
  logic             w_release;
  logic             w_wbank_full;
  logic             w_accept;
  logic             w_drop;
  logic             w_wr_last;

  // A bank released this cycle counts as free for the fill side.
  assign w_release    = (r_state == DONE);
  assign w_wbank_full = w_full[r_wsel] && !(w_release && (r_rsel == r_wsel));
  assign w_accept     = in_valid && !w_wbank_full;
  assign w_drop       = in_valid && w_wbank_full;
  assign w_wr_last    = &r_widx;

  pingpong_buffer #(
    .width (width),
    .N_2   (N_2)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (w_accept),
    .i_wr_sel  (r_wsel),
    .i_wr_addr (r_widx),
    .i_wr_data (in_data),
    .i_wr_last (w_wr_last),
    .i_rel_en  (w_release),
    .i_rel_sel (r_rsel),
    .i_rd_sel  (r_rsel),
    .i_rd_addr (r_ridx),
    .o_rd_data (w_rd_data),
    .o_full    (w_full)
  );

  // Fill side: advance the write index, swap banks after the last word,
  // and flag each dropped sample one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wsel     <= 1'b0;
      r_widx     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= w_drop;
      if (w_accept) begin
        r_widx <= r_widx + N_2'(1);
        if (w_wr_last) begin
          r_wsel <= ~r_wsel;
        end
      end
    end
  end

  // Drain side state register, read index and read-bank select.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_rsel  <= 1'b0;
      r_ridx  <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == LOAD) begin
        r_ridx <= r_ridx + N_2'(1);
      end
      if (w_release) begin
        r_rsel <= ~r_rsel;
      end
    end
  end

  // Drain FSM next state and state-decoded outputs.
  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    fft_load     = 1'b0;
    fft_start    = 1'b0;
    frame_done   = 1'b0;
    fft_rd       = '0;
    case (r_state)
      IDLE: begin
        if (w_full[r_rsel] && !fft_done) begin
          w_next_state = LOAD;
        end
      end
      LOAD: begin
        fft_load = 1'b1;
        fft_rd   = w_rd_data;
        if (&r_ridx) begin
          w_next_state = RUN;
        end
      end
      RUN: begin
        fft_start = 1'b1;
        if (fft_done) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        frame_done   = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign overflow = r_overflow;

`ifdef FFT_DROP_COUNT_EN
  logic [DROP_CNT_W-1:0] r_drop_count;

  // Saturating count of dropped samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_drop_count <= '0;
    end else if (w_drop && (r_drop_count != DROP_CNT_MAX)) begin
      r_drop_count <= r_drop_count + DROP_CNT_W'(1);
    end
  end

  assign drop_count = r_drop_count;
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Self-checking bench for fft_frame_ctrl. Stored samples are pushed to a
// queue as they are driven and popped on every fft_load cycle.
module tb_fft_frame_ctrl;
  import fft_pkg::*;

  localparam int WIDTH = 16;
  localparam int N_2   = 5;
  localparam int N     = 1 << N_2;

`ifdef FFT_DROP_COUNT_EN
  localparam logic [15:0] EXP_DROPS = 16'd32;
`else
  localparam logic [15:0] EXP_DROPS = 16'd0;
`endif

  logic                    clk;
  logic                    reset;
  logic                    in_valid;
  logic signed [WIDTH-1:0] in_data;
  logic                    fft_done;
  logic                    fft_load;
  logic signed [WIDTH-1:0] fft_rd;
  logic                    fft_start;
  logic                    frame_done;
  logic                    overflow;
  logic [15:0]             drop_count;

  int               n_checks;
  int               n_errors;
  logic [WIDTH-1:0] exp_q[$];
  int               load_cycles;
  int               ovf_cnt;
  int               fd_cnt;
  logic             prev_load;

  fft_frame_ctrl #(
    .width (WIDTH),
    .N_2   (N_2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .fft_done   (fft_done),
    .fft_load   (fft_load),
    .fft_rd     (fft_rd),
    .fft_start  (fft_start),
    .frame_done (frame_done),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: observe outputs at the falling edge, then release the caller
  // 1 ns later to drive the next inputs.
  task automatic tick();
    logic [WIDTH-1:0] exp_v;
    @(negedge clk);
    n_checks++;
    if (fft_load === 1'b1) begin
      load_cycles++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL sb_empty: fft_rd=%0d with no expected sample", fft_rd);
      end else begin
        exp_v = exp_q.pop_front();
        if (fft_rd !== exp_v) begin
          n_errors++;
          $display("FAIL sb_data: fft_rd=%0d expected %0d", fft_rd, exp_v);
        end
      end
      n_checks++;
      if (fft_start !== 1'b0) begin
        n_errors++;
        $display("FAIL load_start_overlap: fft_start=%b during fft_load", fft_start);
      end
    end else if (fft_rd !== '0) begin
      n_errors++;
      $display("FAIL rd_idle: fft_rd=%0d expected 0 outside load", fft_rd);
    end
    if (prev_load && (fft_load !== 1'b1) && !reset) begin
      n_checks++;
      if (fft_start !== 1'b1) begin
        n_errors++;
        $display("FAIL start_follow: fft_start=%b expected 1 after load", fft_start);
      end
    end
    prev_load = (fft_load === 1'b1);
    if (overflow === 1'b1) ovf_cnt++;
    if (frame_done === 1'b1) fd_cnt++;
    #1;
  endtask

  task automatic clear_counts();
    load_cycles = 0;
    ovf_cnt     = 0;
    fd_cnt      = 0;
  endtask

  task automatic apply_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    fft_done = 1'b0;
    exp_q.delete();
    tick();
    tick();
    reset = 1'b0;
    clear_counts();
    tick();
  endtask

  task automatic send_range(input int first, input int last, input bit store);
    for (int v = first; v <= last; v++) begin
      in_valid = 1'b1;
      in_data  = WIDTH'(v);
      if (store) exp_q.push_back(WIDTH'(v));
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_start(input string name, input int budget);
    int k = 0;
    while ((fft_start !== 1'b1) && (k < budget)) begin
      tick();
      k++;
    end
    n_checks++;
    if (fft_start !== 1'b1) begin
      n_errors++;
      $display("FAIL %s: fft_start=%b after %0d cycles, expected 1", name, fft_start, k);
    end
  endtask

  task automatic finish_frame();
    fft_done = 1'b1;
    tick();
    tick();
    fft_done = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    fft_done = 1'b0;
    tick();
    tick();
    n_checks++;
    if (fft_load !== 1'b0) begin n_errors++; $display("FAIL rst_load: got %b expected 0", fft_load); end
    n_checks++;
    if (fft_start !== 1'b0) begin n_errors++; $display("FAIL rst_start: got %b expected 0", fft_start); end
    n_checks++;
    if (frame_done !== 1'b0) begin n_errors++; $display("FAIL rst_frame_done: got %b expected 0", frame_done); end
    n_checks++;
    if (overflow !== 1'b0) begin n_errors++; $display("FAIL rst_overflow: got %b expected 0", overflow); end
    n_checks++;
    if (drop_count !== 16'd0) begin n_errors++; $display("FAIL rst_drop_count: got %0d expected 0", drop_count); end
    n_checks++;
    if (dut.r_state !== IDLE) begin n_errors++; $display("FAIL rst_state: got %0d expected IDLE", dut.r_state); end
    n_checks++;
    if (dut.w_full !== 2'b00) begin n_errors++; $display("FAIL rst_full: got %b expected 00", dut.w_full); end
    reset = 1'b0;
    clear_counts();
    tick();
  endtask

  // 32 samples fill bank 0 and stream out as 1..32, then compute starts.
  task automatic test_single_frame();
    send_range(1, N, 1'b1);
    wait_start("single_start_timeout", 100);
    n_checks++;
    if (load_cycles !== N) begin n_errors++; $display("FAIL single_load_len: got %0d expected %0d", load_cycles, N); end
    n_checks++;
    if (exp_q.size() !== 0) begin n_errors++; $display("FAIL single_sb_left: got %0d expected 0", exp_q.size()); end
  endtask

  // Core finishes 40 cycles into compute: start drops, one frame_done, bank 0 freed.
  task automatic test_fft_done();
    int hi = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (fft_start === 1'b1) hi++;
    end
    n_checks++;
    if (hi !== 40) begin n_errors++; $display("FAIL done_start_hold: got %0d cycles expected 40", hi); end
    fft_done = 1'b1;
    tick();
    n_checks++;
    if (fft_start !== 1'b0) begin n_errors++; $display("FAIL done_start_low: got %b expected 0", fft_start); end
    n_checks++;
    if (frame_done !== 1'b1) begin n_errors++; $display("FAIL done_pulse: got %b expected 1", frame_done); end
    tick();
    n_checks++;
    if (frame_done !== 1'b0) begin n_errors++; $display("FAIL done_pulse_end: got %b expected 0", frame_done); end
    n_checks++;
    if (dut.r_state !== IDLE) begin n_errors++; $display("FAIL done_state: got %0d expected IDLE", dut.r_state); end
    n_checks++;
    if (dut.w_full[0] !== 1'b0) begin n_errors++; $display("FAIL done_bank0_free: got %b expected 0", dut.w_full[0]); end
    n_checks++;
    if (fd_cnt !== 1) begin n_errors++; $display("FAIL done_pulse_count: got %0d expected 1", fd_cnt); end
    fft_done = 1'b0;
    tick();
  endtask

  // 96 samples with the core stalled: 64 stored, 32 dropped. Then a sample
  // arriving in the release cycle of the full write bank is kept, and the
  // second bank waits in IDLE until fft_done falls.
  task automatic test_overflow();
    apply_reset();
    for (int v = 1; v <= 3 * N; v++) begin
      in_valid = 1'b1;
      in_data  = WIDTH'(v);
      if (v <= 2 * N) exp_q.push_back(WIDTH'(v));
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    n_checks++;
    if (ovf_cnt !== N) begin n_errors++; $display("FAIL ovf_pulses: got %0d expected %0d", ovf_cnt, N); end
    n_checks++;
    if (drop_count !== EXP_DROPS) begin n_errors++; $display("FAIL ovf_drop_count: got %0d expected %0d", drop_count, EXP_DROPS); end
    n_checks++;
    if (exp_q.size() !== N) begin n_errors++; $display("FAIL ovf_sb_left: got %0d expected %0d", exp_q.size(), N); end
    n_checks++;
    if (fft_start !== 1'b1) begin n_errors++; $display("FAIL ovf_running: got %b expected 1", fft_start); end
    fft_done = 1'b1;
    tick();
    in_valid = 1'b1;
    in_data  = WIDTH'(97);
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (overflow !== 1'b0) begin n_errors++; $display("FAIL release_collide_ovf: got %b expected 0", overflow); end
    n_checks++;
    if (dut.r_widx !== N_2'(1)) begin n_errors++; $display("FAIL release_collide_widx: got %0d expected 1", dut.r_widx); end
    for (int i = 0; i < 10; i++) tick();
    n_checks++;
    if (dut.r_state !== IDLE) begin n_errors++; $display("FAIL hold_idle_state: got %0d expected IDLE", dut.r_state); end
    n_checks++;
    if (load_cycles !== N) begin n_errors++; $display("FAIL hold_idle_load: got %0d expected %0d", load_cycles, N); end
    fft_done = 1'b0;
    wait_start("hold_idle_start_timeout", 100);
    n_checks++;
    if (load_cycles !== 2 * N) begin n_errors++; $display("FAIL hold_idle_load2: got %0d expected %0d", load_cycles, 2 * N); end
    n_checks++;
    if (drop_count !== EXP_DROPS) begin n_errors++; $display("FAIL ovf_drop_final: got %0d expected %0d", drop_count, EXP_DROPS); end
    finish_frame();
  endtask

  // Sample 64 completes bank 1 on the same edge DONE releases bank 0.
  task automatic test_back_to_back();
    apply_reset();
    send_range(1, N, 1'b1);
    wait_start("b2b_start1_timeout", 100);
    send_range(N + 1, 2 * N - 1, 1'b1);
    fft_done = 1'b1;
    tick();
    n_checks++;
    if (frame_done !== 1'b1) begin n_errors++; $display("FAIL b2b_done_cycle: got %b expected 1", frame_done); end
    in_valid = 1'b1;
    in_data  = WIDTH'(2 * N);
    exp_q.push_back(WIDTH'(2 * N));
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (overflow !== 1'b0) begin n_errors++; $display("FAIL b2b_ovf: got %b expected 0", overflow); end
    n_checks++;
    if (dut.w_full !== 2'b10) begin n_errors++; $display("FAIL b2b_full: got %b expected 10", dut.w_full); end
    fft_done = 1'b0;
    wait_start("b2b_start2_timeout", 100);
    n_checks++;
    if (load_cycles !== 2 * N) begin n_errors++; $display("FAIL b2b_load_len: got %0d expected %0d", load_cycles, 2 * N); end
    n_checks++;
    if (ovf_cnt !== 0) begin n_errors++; $display("FAIL b2b_ovf_total: got %0d expected 0", ovf_cnt); end
    finish_frame();
  endtask

  // Reset on the tenth load cycle abandons the frame; a fresh frame loads fully.
  task automatic test_reset_mid_load();
    int k = 0;
    apply_reset();
    send_range(1, N, 1'b1);
    while ((load_cycles < 10) && (k < 100)) begin
      tick();
      k++;
    end
    n_checks++;
    if (load_cycles !== 10) begin n_errors++; $display("FAIL midrst_reach: got %0d load cycles expected 10", load_cycles); end
    reset = 1'b1;
    exp_q.delete();
    tick();
    n_checks++;
    if (fft_load !== 1'b0) begin n_errors++; $display("FAIL midrst_load_low: got %b expected 0", fft_load); end
    reset = 1'b0;
    clear_counts();
    tick();
    send_range(101, 100 + N, 1'b1);
    wait_start("midrst_start_timeout", 100);
    n_checks++;
    if (load_cycles !== N) begin n_errors++; $display("FAIL midrst_load_len: got %0d expected %0d", load_cycles, N); end
    n_checks++;
    if (exp_q.size() !== 0) begin n_errors++; $display("FAIL midrst_sb_left: got %0d expected 0", exp_q.size()); end
    finish_frame();
    n_checks++;
    if (fd_cnt !== 1) begin n_errors++; $display("FAIL midrst_frame_done: got %0d expected 1", fd_cnt); end
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    prev_load = 1'b0;
    clear_counts();
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    fft_done = 1'b0;
    test_reset();
    test_single_frame();
    test_fft_done();
    test_overflow();
    test_back_to_back();
    test_reset_mid_load();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
